column_scanner: RTL
===================

# column_scanner

Parametrised column scanner for the LED matrix driver, and the successor to the fixed 3-bit column selector. It generates a one-hot rotating column drive for any column count, with optional mirror folding and a programmable dwell time per column. It also inserts anti-ghosting blank gaps between columns, marks frame boundaries, and self-recovers from a corrupted ring. It sits between the system clock and the matrix row/column drivers; the row-data logic uses `col_index` and `frame_start` to fetch pixel data.

## Interface
- `COLUMNS`, default 5: physical matrix columns; must be ≥ 2.
- `MIRROR`, default 1: when 1, images are left/right symmetric and physical columns j and COLUMNS-1-j are driven together.
- `DWELL`, default 4: clock cycles each column is lit; must be ≥ 1.
- `BLANK`, default 1: all-off clock cycles after each column; must be ≥ 0.
- Derived: U = MIRROR ? (COLUMNS+1)/2 : COLUMNS (unique columns). IW = max(1, clog2(U)).
- `clock`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scan enable; low forces idle.
- `col`  out  U  one-hot unique-column drive; all zero when not showing.
- `col_phys`  out  COLUMNS  physical column drive; mirror-expanded from `col`.
- `col_index`  out  IW  binary index of the current/next unique column.
- `frame_start`  out  1  one-cycle pulse on the first lit cycle of column 0.
- `blanking`  out  1  high whenever `col` is all zero (IDLE or BLANK).
- `ring_fault`  out  1  one-cycle pulse when a non-one-hot ring is detected and repaired.

## Operation
- **State machine:** IDLE, SHOW, BLANK.
- **Registers:**
  - ring register, U bits, one-hot;
  - cycle counter, sized for max(DWELL, BLANK).
- **Outputs:** all outputs are decoded from registers only. There is no combinational path from `enable` to any output.
- **Reset:** state=IDLE, ring=bit 0, counter=0. Outputs: `col`=0, `col_phys`=0, `col_index`=0, `frame_start`=0, `blanking`=1, `ring_fault`=0.
- **IDLE:** outputs blank. When `enable` is 1, go to SHOW with ring=bit 0 and counter=0.
- **SHOW:**
  - `col`=ring, `col_index`=encode(ring).
  - The counter increments each cycle.
  - At counter==DWELL-1: rotate ring left (bit U-1 wraps to bit 0) and clear the counter. Go to BLANK if BLANK>0; otherwise stay in SHOW on the next column.
- **BLANK:** `col`=0 and `col_index` holds the next column. At counter==BLANK-1, clear the counter and go to SHOW.
- **`frame_start`:** high exactly in the first SHOW cycle where ring=bit 0, both after IDLE exit and after wrap-around from column U-1.
- **`enable` low in any state:** next state is IDLE, ring returns to bit 0, counter clears. A partial frame is abandoned and never resumed.
- **Mirror mapping:** `col_phys`[j] = `col`[min(j, COLUMNS-1-j)]. For odd COLUMNS the centre column is single. When MIRROR=0, `col_phys` = `col`.
- **Ring fault:** if the ring is not exactly one-hot in SHOW or BLANK, the next state is SHOW with ring=bit 0 and counter=0, and `ring_fault` pulses. This takes priority over normal counting; `enable` low still takes priority over fault recovery.
- **Frame length:** U×(DWELL+BLANK) cycles. The default configuration gives 3×5 = 15 cycles.

## Timing
- **Enable to first column:** one cycle. The edge that samples `enable`=1 in IDLE is followed by a cycle with `col`=1 and `frame_start`=1.
- **Enable low to blank:** one cycle. The edge that samples `enable`=0 is followed by `col`=0 and `blanking`=1.
- **Column lit time:** each column is lit for exactly DWELL consecutive cycles, followed by exactly BLANK cycles of `col`=0.
- **BLANK=0:** columns are back-to-back and `blanking` stays low throughout the scan.
- **U=1** (COLUMNS=2, MIRROR=1): the ring stays at bit 0 and `frame_start` pulses every DWELL+BLANK cycles.
- **Asynchronous reset mid-scan:** outputs go to their reset values immediately, without waiting for a clock edge. Scanning resumes from column 0 one cycle after the first edge at which `reset_n`=1 and `enable`=1 are both sampled.

## Structure
- **Package `matrix_pkg`:**
  - scan state enum: IDLE, SHOW, BLANK;
  - function `unique_cols(COLUMNS, MIRROR)`;
  - function `onehot_to_index`;
  - function `is_onehot`.
- **Sub-module `ring_counter`:** parametrised width W, with inputs `clock`, `reset_n`, `load` (forces bit 0), `advance` (rotate left), and output `q`.
- **`column_scanner` top:** contains the FSM, the counter, the mirror expansion and the fault check.

## Test plan
- **Default config, enable held high from reset release:**
  - `col` sequence is 001×4, 000, 010×4, 000, 100×4, 000, repeating;
  - `col_phys` sequences 10001, 01010, 00100;
  - `frame_start` pulses every 15 cycles.
- **MIRROR=0, COLUMNS=4, DWELL=2, BLANK=0:** `col` is 0001,0001,0010,0010,0100,0100,1000,1000 then wraps; `blanking` is never high; `col_index` is 0,0,1,1,2,2,3,3.
- **Default config, `enable` dropped during column 1, dwell cycle 2:** the next cycle `col`=0 and `blanking`=1. On re-enable, `col`=001 and `frame_start`=1 one cycle later.
- **Assert `reset_n` low asynchronously mid-column 2:** outputs clear before the next edge. After release with `enable`=1, the scan restarts at `col`=001.
- **Force the ring to 011 during SHOW:** the next cycle has `ring_fault`=1, `col`=001 and `frame_start`=1. The scan then continues normally.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the LED matrix column scanner.
package matrix_pkg;

  // Widest ring the helper functions accept.
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } scan_state_t;

  // Number of distinct column patterns; mirrored images share halves.
  function automatic int unique_cols(int columns, int mirror);
    return (mirror != 0) ? (columns + 1) / 2 : columns;
  endfunction

  // Binary position of the set bit of a one-hot vector.
  function automatic int onehot_to_index(logic [MAX_W-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ring_counter.sv
// One-hot rotating ring with synchronous load-to-bit-0 and rotate-left.
module ring_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] BIT0 = W'(1);

  // Load wins over advance; rotation wraps the top bit into bit 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= BIT0;
    end else if (load) begin
      q <= BIT0;
    end else if (advance) begin
      q <= (q << 1) | (q >> (W - 1));
    end
  end

endmodule

// File: rtl/column_scanner.sv
// Column scanner: dwell/blank sequencing, frame marking, mirror expansion
// and ring self-repair for the LED matrix column drivers.
module column_scanner
  import matrix_pkg::*;
#(
  parameter int COLUMNS = 5,
  parameter int MIRROR  = 1,
  parameter int DWELL   = 4,
  parameter int BLANK   = 1,
  localparam int U      = unique_cols(COLUMNS, MIRROR),
  localparam int IW     = (U > 1) ? $clog2(U) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  output logic [U-1:0]       col,
  output logic [COLUMNS-1:0] col_phys,
  output logic [IW-1:0]      col_index,
  output logic               frame_start,
  output logic               blanking,
  output logic               ring_fault
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  scan_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [U-1:0]  ring;
  logic          load, advance, fault, fs_nx;

  ring_counter #(.W(U)) u_ring (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .advance (advance),
    .q       (ring)
  );

  // Next-state logic: enable-low beats fault repair, which beats counting.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    advance  = 1'b0;
    fault    = 1'b0;
    if (!enable) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      load     = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_SHOW;
          cnt_nx   = '0;
          load     = 1'b1;
        end
        S_SHOW, S_BLANK: begin
          if (!is_onehot(MAX_W'(ring))) begin
            fault    = 1'b1;
            state_nx = S_SHOW;
            cnt_nx   = '0;
            load     = 1'b1;
          end else if (state == S_SHOW) begin
            if (cnt == DWELL_LAST) begin
              advance  = 1'b1;
              cnt_nx   = '0;
              state_nx = (BLANK > 0) ? S_BLANK : S_SHOW;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end else begin
            if (cnt == BLANK_LAST) begin
              cnt_nx   = '0;
              state_nx = S_SHOW;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          load     = 1'b1;
        end
      endcase
    end
    // A frame begins on the first cycle column 0 is shown; the ring value
    // it will hold is bit 0 after a load, after wrapping from the top bit,
    // or when leaving a blank gap that already rotated back to bit 0.
    fs_nx = (state_nx == S_SHOW) && (cnt_nx == '0) &&
            (load ? 1'b1 : (advance ? ring[U-1] : ring[0]));
  end

  // Control registers, including the registered frame and fault pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      frame_start <= 1'b0;
      ring_fault  <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      frame_start <= fs_nx;
      ring_fault  <= fault;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    col       = (state == S_SHOW) ? ring : '0;
    col_index = IW'(onehot_to_index(MAX_W'(ring)));
    blanking  = (col == '0);
  end

  // Mirror folding: physical column j follows the nearer edge's unique column.
  for (genvar j = 0; j < COLUMNS; j++) begin : g_phys
    localparam int SRC = (MIRROR != 0) ?
                         ((j < COLUMNS - 1 - j) ? j : COLUMNS - 1 - j) : j;
    assign col_phys[j] = col[SRC];
  end

endmodule
